// File: rtl/axi_bram_slave.sv
// AXI4 full slave with an integrated single-port memory. One transaction is active at a time.
// The read channel has an output register plus a one-entry skid buffer for full rate under backpressure.
module axi_bram_slave #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int ID_W   = 4
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

  state_t              state_q, state_d;
  logic                rd_prio_q, rd_prio_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          burst_q, burst_d;
  logic                err_q, err_d;
  logic                issuing_q, issuing_d;
  logic                r_valid_q, r_valid_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic [1:0]          r_resp_q, r_resp_d;
  logic                r_last_q, r_last_d;
  logic                s_valid_q, s_valid_d;
  logic [DATA_W-1:0]   s_data_q, s_data_d;
  logic [1:0]          s_resp_q, s_resp_d;
  logic                s_last_q, s_last_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   mem_rd;
  logic [DATA_W-1:0]   rd_word;
  logic [1:0]          rd_resp;
  logic                mem_we;
  logic                rd_issue;
  logic                rd_pop;
  logic                beat_last;
  logic                idx_oor;
  logic                wrap_en;
  logic [ADDR_W-1:0]   wrap_mask;
  logic [ADDR_W-1:0]   idx_inc;
  logic [ADDR_W-1:0]   idx_nxt;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^{s_axi_awaddr[OFFS-1:0], s_axi_araddr[OFFS-1:0]};

  // Index is kept at full address width so beats past DEPTH are flagged instead of aliasing.
  assign idx_oor = (idx_q >= ADDR_W'(DEPTH));
  assign mem_rd  = mem[idx_q[IDX_W-1:0]];
  assign rd_word = idx_oor ? '0 : mem_rd;
  assign rd_resp = idx_oor ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    idx_inc   = idx_q + ADDR_W'(1);
    wrap_mask = ADDR_W'(len_q);
    wrap_en   = (burst_q == 2'b10) &&
                (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
    if (burst_q == 2'b00)
      idx_nxt = idx_q;
    else if (wrap_en)
      idx_nxt = (idx_q & ~wrap_mask) | (idx_inc & wrap_mask);
    else
      idx_nxt = idx_inc;
  end

  always_comb begin
    state_d   = state_q;
    rd_prio_d = rd_prio_q;
    id_d      = id_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    err_d     = err_q;
    issuing_d = issuing_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_resp_d  = s_resp_q;
    s_last_d  = s_last_q;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    mem_we    = 1'b0;
    rd_issue  = 1'b0;
    beat_last = (cnt_q == len_q);
    rd_pop    = r_valid_q && s_axi_rready;

    case (state_q)
      IDLE: begin
        if (s_axi_awvalid && !(s_axi_arvalid && rd_prio_q)) begin
          s_axi_awready = 1'b1;
          id_d      = s_axi_awid;
          idx_d     = s_axi_awaddr >> OFFS;
          len_d     = s_axi_awlen;
          burst_d   = s_axi_awburst;
          cnt_d     = '0;
          err_d     = 1'b0;
          rd_prio_d = 1'b1;
          state_d   = WR_DATA;
        end else if (s_axi_arvalid) begin
          s_axi_arready = 1'b1;
          id_d      = s_axi_arid;
          idx_d     = s_axi_araddr >> OFFS;
          len_d     = s_axi_arlen;
          burst_d   = s_axi_arburst;
          cnt_d     = '0;
          issuing_d = 1'b1;
          rd_prio_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_we = s_axi_aresetn && !idx_oor;
          if (idx_oor || (s_axi_wlast != beat_last))
            err_d = 1'b1;
          if (beat_last) begin
            state_d = WR_RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
            idx_d = idx_nxt;
          end
        end
      end
      WR_RESP: begin
        if (s_axi_bready)
          state_d = IDLE;
      end
      RD_DATA: begin
        // A read is only issued when R or the skid slot will be free to receive it.
        rd_issue = issuing_q && (!s_valid_q || rd_pop);
        if (rd_issue) begin
          if (beat_last) begin
            issuing_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
            idx_d = idx_nxt;
          end
        end
        if (rd_pop && r_last_q)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rd_pop || !r_valid_q) begin
      if (s_valid_q) begin
        r_valid_d = 1'b1;
        r_data_d  = s_data_q;
        r_resp_d  = s_resp_q;
        r_last_d  = s_last_q;
        s_valid_d = rd_issue;
        if (rd_issue) begin
          s_data_d = rd_word;
          s_resp_d = rd_resp;
          s_last_d = beat_last;
        end
      end else begin
        r_valid_d = rd_issue;
        if (rd_issue) begin
          r_data_d = rd_word;
          r_resp_d = rd_resp;
          r_last_d = beat_last;
        end
      end
    end else if (rd_issue) begin
      s_valid_d = 1'b1;
      s_data_d  = rd_word;
      s_resp_d  = rd_resp;
      s_last_d  = beat_last;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      rd_prio_q <= 1'b0;
      id_q      <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      issuing_q <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_resp_q  <= '0;
      s_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_prio_q <= rd_prio_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      issuing_q <= issuing_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_resp_q  <= s_resp_d;
      s_last_q  <= s_last_d;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b])
          mem[idx_q[IDX_W-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi_bvalid = (state_q == WR_RESP);
  assign s_axi_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_bid    = id_q;
  assign s_axi_rid    = id_q;
  assign s_axi_rvalid = r_valid_q;
  assign s_axi_rdata  = r_data_q;
  assign s_axi_rresp  = r_resp_q;
  assign s_axi_rlast  = r_last_q;

endmodule

// File: tb/tb_axi_bram_slave.sv
// Scoreboard bench for axi_bram_slave: expected R/B results are queued at stimulus time
// and compared when the DUT presents them.
module tb_axi_bram_slave;

  localparam int DW  = 64;
  localparam int AW  = 16;
  localparam int DEP = 16;
  localparam int IW  = 4;

  logic          clk;
  logic          aresetn;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  axi_bram_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .ID_W(IW)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } rexp_t;

  rexp_t         rq[$];
  logic [5:0]    bq[$];
  logic [DW-1:0] model_mem [DEP];
  int            n_chk = 0;
  int            n_bad = 0;
  bit            throttle = 0;
  bit            mute = 0;
  logic [7:0]    glog = '0;
  rexp_t         mon_e;
  logic [5:0]    mon_b;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] nidx(input logic [15:0] i, input logic [1:0] b, input logic [7:0] l);
    logic [15:0] m;
    if (b == 2'b00) return i;
    if (b == 2'b10 && (l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)) begin
      m = {8'h00, l};
      return (i & ~m) | ((i + 16'd1) & m);
    end
    return i + 16'd1;
  endfunction

  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (awvalid && awready) glog = {glog[5:0], 2'b01};
    if (arvalid && arready) glog = {glog[5:0], 2'b10};
    if (!mute && rvalid) begin
      if (rq.size() == 0) begin
        chk("r_unexpected", rvalid, 1'b0);
      end else if (rready) begin
        mon_e = rq.pop_front();
        chk("r_data", rdata, mon_e.data);
        chk("r_resp", rresp, mon_e.resp);
        chk("r_last", rlast, mon_e.last);
        chk("r_id", rid, mon_e.id);
      end else begin
        chk("r_stall", rdata, rq[0].data);
      end
    end
    if (bvalid && bready) begin
      if (bq.size() == 0) begin
        chk("b_unexpected", bvalid, 1'b0);
      end else begin
        mon_b = bq.pop_front();
        chk("b_id", bid, mon_b[5:2]);
        chk("b_resp", bresp, mon_b[1:0]);
      end
    end
  end

  task automatic do_write(input logic [IW-1:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [DW-1:0] d0, input logic [DW-1:0] step,
                          input logic [7:0] strb, input int bad_beat);
    logic [15:0]   idx;
    logic          err;
    logic          lst;
    logic [DW-1:0] d;
    int            n;
    idx = addr >> 3;
    err = 1'b0;
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 200);
    chk("aw_grant", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      lst = (b == int'(len));
      if (b == bad_beat) lst = !lst;
      d = d0 + DW'(b) * step;
      wdata = d; wstrb = strb; wlast = lst; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 50);
      chk("w_ready", wready, 1'b1);
      if (idx >= 16'(DEP)) err = 1'b1;
      else
        for (int k = 0; k < DW / 8; k++)
          if (strb[k]) model_mem[idx[3:0]][k*8 +: 8] = d[k*8 +: 8];
      if (lst != (b == int'(len))) err = 1'b1;
      idx = nidx(idx, burst, len);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bq.push_back({id, err ? 2'b10 : 2'b00});
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit chk_lat);
    logic [15:0] idx;
    rexp_t       e;
    int          n;
    idx = addr >> 3;
    for (int b = 0; b <= int'(len); b++) begin
      e.data = (idx >= 16'(DEP)) ? '0 : model_mem[idx[3:0]];
      e.resp = (idx >= 16'(DEP)) ? 2'b10 : 2'b00;
      e.last = (b == int'(len));
      e.id   = id;
      rq.push_back(e);
      idx = nidx(idx, burst, len);
    end
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 200);
    chk("ar_grant", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    if (chk_lat) chk("r_latency", n, 2);
    n = 0;
    while (rq.size() != 0 && n < 400) begin @(negedge clk); n++; end
    chk("r_drain", rq.size(), 0);
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {awready, arready, wready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp, rlast}, 5'b0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_ids", {bid, rid}, 8'h00);
    @(posedge clk); #1;
    aresetn = 1'b1;

    do_write(4'd1, 16'h0000, 8'd15, 2'b01, 64'hA5A5_0000_0000_0000, 64'h0000_0101_0000_0001, 8'hFF, -1);
    do_write(4'd3, 16'h0040, 8'd3, 2'b01, 64'd1, 64'd1, 8'hFF, -1);
    do_read(4'd5, 16'h0040, 8'd3, 2'b01, 1'b1);

    do_write(4'd2, 16'h0028, 8'd0, 2'b01, '1, 64'd0, 8'hFF, -1);
    do_write(4'd2, 16'h0028, 8'd0, 2'b01, 64'd0, 64'd0, 8'h01, -1);
    do_read(4'd6, 16'h0028, 8'd0, 2'b01, 1'b1);

    do_read(4'd7, 16'h0030, 8'd3, 2'b10, 1'b0);
    do_read(4'd8, 16'h0030, 8'd2, 2'b10, 1'b0);
    do_read(4'd4, 16'h0040, 8'd2, 2'b00, 1'b0);

    do_write(4'd9, 16'h0070, 8'd3, 2'b01, 64'h0000_BEEF_0000_0000, 64'd1, 8'hFF, -1);
    do_read(4'd10, 16'h0070, 8'd3, 2'b01, 1'b0);
    do_read(4'd11, 16'h0000, 8'd0, 2'b01, 1'b0);

    do_write(4'd12, 16'h0060, 8'd1, 2'b01, 64'h0C0C_0000_0000_0000, 64'd7, 8'hFF, 0);
    do_read(4'd13, 16'h0060, 8'd1, 2'b01, 1'b0);

    throttle = 1'b1;
    do_read(4'd14, 16'h0000, 8'd15, 2'b01, 1'b0);
    throttle = 1'b0;

    fork
      begin
        do_write(4'd1, 16'h0010, 8'd1, 2'b01, 64'h2222_0000_0000_0000, 64'd1, 8'hFF, -1);
        do_write(4'd2, 16'h0018, 8'd0, 2'b01, 64'h3333_0000_0000_0000, 64'd0, 8'hFF, -1);
      end
      do_read(4'd3, 16'h0050, 8'd1, 2'b01, 1'b0);
    join
    chk("grant_order", glog[5:0], 6'b01_10_01);
    do_read(4'd4, 16'h0010, 8'd1, 2'b01, 1'b0);

    mute = 1'b1;
    @(posedge clk); #1;
    arid = 4'd15; araddr = 16'h0000; arlen = 8'd15; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    chk("mid_ar_grant", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1 aresetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rvalid", rvalid, 1'b0);
    chk("midrst_bvalid", bvalid, 1'b0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    chk("postrst_rvalid", rvalid, 1'b0);
    mute = 1'b0;
    do_read(4'd6, 16'h0040, 8'd0, 2'b01, 1'b1);

    repeat (5) @(negedge clk);
    chk("sb_empty", rq.size() + bq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
